// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller and its emergency request path.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EMG_MINOR = 2'd1,
    EMG_MAJOR = 2'd2
  } emg_state_e;

  localparam int unsigned MIN_HOLD_DEF = 5;
  localparam int unsigned MAX_HOLD_DEF = 60;
  localparam int unsigned CNT_W_DEF    = 8;

  // Phase durations in seconds used by the main controller.
  localparam int unsigned T_MAJOR_GREEN = 40;
  localparam int unsigned T_MINOR_GREEN = 20;
  localparam int unsigned T_YELLOW      = 5;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for one raw switch plus an armed rising-edge detector.
module btn_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic rise_o
);

  logic       s1_q, s2_q, prev_q, armed_q, armed_d;
  logic [1:0] fill_q;

  // The sync flops hold reset zeros for two edges; only a genuinely sampled
  // low level may arm the detector, so a switch held across reset stays silent.
  assign armed_d = armed_q | (fill_q[1] & ~s2_q);
  assign rise_o  = s2_q & ~prev_q & armed_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      fill_q  <= 2'b00;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      armed_q <= armed_d;
      fill_q  <= {fill_q[0], 1'b1};
    end
  end

endmodule

// File: rtl/emergency_request_ctrl.sv
// Turns the S0/S1 emergency switches into mutually exclusive, time-bounded
// minor/major emergency requests for the traffic light controller.
module emergency_request_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_HOLD = MIN_HOLD_DEF,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk_1Hz,
  input  logic             rst,
  input  logic             btn_minor,
  input  logic             btn_major,
  output logic             minor_emergency,
  output logic             major_emergency,
  output logic [CNT_W-1:0] emg_remaining,
  output logic             timeout_pulse,
  output logic             reject_pulse,
  output emg_state_e       state_dbg
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_HOLD);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_HOLD);

  emg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, rem_q, rem_d;
  logic             rej_q, rej_d, to_q, to_d;
  logic             rise_minor, rise_major, own_rise, other_rise;

  btn_sync_edge u_sync_minor (
    .clk_i  (clk_1Hz),
    .rst_i  (rst),
    .btn_i  (btn_minor),
    .rise_o (rise_minor)
  );

  btn_sync_edge u_sync_major (
    .clk_i  (clk_1Hz),
    .rst_i  (rst),
    .btn_i  (btn_major),
    .rise_o (rise_major)
  );

  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      rej_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      rej_q   <= rej_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rej_d      = 1'b0;
    to_d       = 1'b0;
    own_rise   = (state_q == EMG_MAJOR) ? rise_major : rise_minor;
    other_rise = (state_q == EMG_MAJOR) ? rise_minor : rise_major;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise_minor) begin
          state_d = EMG_MINOR;
          rej_d   = rise_major;
        end else if (rise_major) begin
          state_d = EMG_MAJOR;
        end
      end
      EMG_MINOR, EMG_MAJOR: begin
        // Auto-release wins over any rise in the same cycle; that rise is dropped.
        if (cnt_q == MAX_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          to_d    = 1'b1;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          if (own_rise) begin
            if (cnt_q >= MIN_CNT) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              rej_d = 1'b1;
            end
          end
          if (other_rise) rej_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    rem_d = (state_d == IDLE) ? '0 : MAX_CNT - cnt_d;
  end

  assign minor_emergency = (state_q == EMG_MINOR);
  assign major_emergency = (state_q == EMG_MAJOR);
  assign emg_remaining   = rem_q;
  assign timeout_pulse   = to_q;
  assign reject_pulse    = rej_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_emergency_request_ctrl.sv
// Directed bench for emergency_request_ctrl: entry latency, rejects, minimum
// hold release, auto-release after 60 s, reset arming and async reset drop.
module tb_emergency_request_ctrl;
  import traffic_pkg::*;

  logic       clk_1Hz = 1'b0;
  logic       rst = 1'b1;
  logic       btn_minor = 1'b0;
  logic       btn_major = 1'b0;
  logic       minor_emergency, major_emergency, timeout_pulse, reject_pulse;
  logic [7:0] emg_remaining;
  emg_state_e state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  emergency_request_ctrl #(.MIN_HOLD(5), .MAX_HOLD(60), .CNT_W(8)) dut (
    .clk_1Hz         (clk_1Hz),
    .rst             (rst),
    .btn_minor       (btn_minor),
    .btn_major       (btn_major),
    .minor_emergency (minor_emergency),
    .major_emergency (major_emergency),
    .emg_remaining   (emg_remaining),
    .timeout_pulse   (timeout_pulse),
    .reject_pulse    (reject_pulse),
    .state_dbg       (state_dbg)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  // Mutual exclusion watch on every falling edge.
  always @(negedge clk_1Hz) begin
    n_checks++;
    if ((minor_emergency & major_emergency) !== 1'b0) begin
      n_fail++;
      $display("FAIL excl: minor=%b major=%b both high at %0t", minor_emergency, major_emergency, $time);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_1Hz);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; btn_minor = 1'b0; btn_major = 1'b0;
    #12;
    n_checks++;
    if ({minor_emergency, major_emergency, timeout_pulse, reject_pulse, emg_remaining} !== 12'h000) begin
      n_fail++; $display("FAIL reset_hold: got %b_%b_%b_%b_%0d want all 0", minor_emergency, major_emergency, timeout_pulse, reject_pulse, emg_remaining);
    end
    @(negedge clk_1Hz);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_checks++;
      if ({minor_emergency, major_emergency, timeout_pulse, reject_pulse, emg_remaining} !== 12'h000) begin
        n_fail++; $display("FAIL reset_idle[%0d]: got %b_%b_%b_%b_%0d want all 0", i, minor_emergency, major_emergency, timeout_pulse, reject_pulse, emg_remaining);
      end
    end
  endtask

  task automatic test_minor_hold;
    btn_minor = 1'b1;
    step(2);
    n_checks++;
    if (minor_emergency !== 1'b0) begin n_fail++; $display("FAIL minor_latency2: got %b want 0", minor_emergency); end
    btn_minor = 1'b0;
    step(1);
    n_checks++;
    if (minor_emergency !== 1'b1 || emg_remaining !== 8'd60) begin
      n_fail++; $display("FAIL minor_entry: got em=%b rem=%0d want em=1 rem=60", minor_emergency, emg_remaining);
    end
    btn_minor = 1'b1;
    step(2);
    n_checks++;
    if (emg_remaining !== 8'd58 || reject_pulse !== 1'b0) begin
      n_fail++; $display("FAIL minor_cnt2: got rem=%0d rej=%b want rem=58 rej=0", emg_remaining, reject_pulse);
    end
    step(1);
    n_checks++;
    if (reject_pulse !== 1'b1 || minor_emergency !== 1'b1 || emg_remaining !== 8'd57) begin
      n_fail++; $display("FAIL minor_early_reject: got rej=%b em=%b rem=%0d want 1 1 57", reject_pulse, minor_emergency, emg_remaining);
    end
    btn_minor = 1'b0;
    step(1);
    n_checks++;
    if (reject_pulse !== 1'b0) begin n_fail++; $display("FAIL reject_width: got %b want 0", reject_pulse); end
    btn_minor = 1'b1;
    step(2);
    n_checks++;
    if (minor_emergency !== 1'b1 || emg_remaining !== 8'd54) begin
      n_fail++; $display("FAIL minor_cnt6: got em=%b rem=%0d want em=1 rem=54", minor_emergency, emg_remaining);
    end
    step(1);
    n_checks++;
    if (minor_emergency !== 1'b0 || emg_remaining !== 8'd0 || reject_pulse !== 1'b0) begin
      n_fail++; $display("FAIL minor_release: got em=%b rem=%0d rej=%b want 0 0 0", minor_emergency, emg_remaining, reject_pulse);
    end
    btn_minor = 1'b0;
    step(4);
  endtask

  task automatic test_simultaneous;
    btn_minor = 1'b1; btn_major = 1'b1;
    step(3);
    n_checks++;
    if (minor_emergency !== 1'b1 || major_emergency !== 1'b0 || reject_pulse !== 1'b1) begin
      n_fail++; $display("FAIL simul_entry: got mi=%b ma=%b rej=%b want 1 0 1", minor_emergency, major_emergency, reject_pulse);
    end
    btn_minor = 1'b0; btn_major = 1'b0;
    step(1);
    n_checks++;
    if (reject_pulse !== 1'b0 || major_emergency !== 1'b0) begin
      n_fail++; $display("FAIL simul_after: got rej=%b ma=%b want 0 0", reject_pulse, major_emergency);
    end
    step(2);
    btn_minor = 1'b1;
    step(2);
    n_checks++;
    if (minor_emergency !== 1'b1) begin n_fail++; $display("FAIL min_hold_pre: got %b want 1", minor_emergency); end
    step(1);
    n_checks++;
    if (minor_emergency !== 1'b0 || reject_pulse !== 1'b0) begin
      n_fail++; $display("FAIL min_hold_release: got em=%b rej=%b want 0 0", minor_emergency, reject_pulse);
    end
    btn_minor = 1'b0;
    step(3);
  endtask

  task automatic test_timeout;
    btn_major = 1'b1;
    step(3);
    n_checks++;
    if (major_emergency !== 1'b1 || emg_remaining !== 8'd60 || timeout_pulse !== 1'b0) begin
      n_fail++; $display("FAIL major_entry: got em=%b rem=%0d to=%b want 1 60 0", major_emergency, emg_remaining, timeout_pulse);
    end
    for (int k = 1; k < 60; k++) begin
      step(1);
      n_checks++;
      if (major_emergency !== 1'b1 || emg_remaining !== 8'(60 - k) || timeout_pulse !== 1'b0
          || reject_pulse !== (k == 13)) begin
        n_fail++; $display("FAIL major_hold[%0d]: got em=%b rem=%0d to=%b rej=%b want 1 %0d 0 %b",
                           k, major_emergency, emg_remaining, timeout_pulse, reject_pulse, 60 - k, k == 13);
      end
      if (k == 10) btn_minor = 1'b1;
    end
    step(1);
    n_checks++;
    if (major_emergency !== 1'b0 || emg_remaining !== 8'd0 || timeout_pulse !== 1'b1) begin
      n_fail++; $display("FAIL timeout_edge: got em=%b rem=%0d to=%b want 0 0 1", major_emergency, emg_remaining, timeout_pulse);
    end
    step(1);
    n_checks++;
    if (timeout_pulse !== 1'b0 || major_emergency !== 1'b0 || minor_emergency !== 1'b0) begin
      n_fail++; $display("FAIL timeout_after: got to=%b ma=%b mi=%b want 0 0 0", timeout_pulse, major_emergency, minor_emergency);
    end
    btn_major = 1'b0; btn_minor = 1'b0;
    step(3);
  endtask

  task automatic test_held_reset;
    btn_major = 1'b1;
    #2 rst = 1'b1;
    #4 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_checks++;
      if (major_emergency !== 1'b0) begin n_fail++; $display("FAIL held_reset[%0d]: got %b want 0", i, major_emergency); end
    end
    btn_major = 1'b0;
    step(3);
    btn_major = 1'b1;
    step(2);
    n_checks++;
    if (major_emergency !== 1'b0) begin n_fail++; $display("FAIL rearm_latency: got %b want 0", major_emergency); end
    step(1);
    n_checks++;
    if (major_emergency !== 1'b1 || emg_remaining !== 8'd60) begin
      n_fail++; $display("FAIL rearm_entry: got em=%b rem=%0d want 1 60", major_emergency, emg_remaining);
    end
  endtask

  task automatic test_async_reset;
    step(20);
    n_checks++;
    if (major_emergency !== 1'b1 || emg_remaining !== 8'd40) begin
      n_fail++; $display("FAIL pre_reset: got em=%b rem=%0d want 1 40", major_emergency, emg_remaining);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (major_emergency !== 1'b0 || minor_emergency !== 1'b0 || emg_remaining !== 8'd0) begin
      n_fail++; $display("FAIL async_drop: got ma=%b mi=%b rem=%0d want 0 0 0", major_emergency, minor_emergency, emg_remaining);
    end
    #3 rst = 1'b0;
    btn_major = 1'b0;
    step(3);
    n_checks++;
    if (major_emergency !== 1'b0 || state_dbg !== IDLE) begin
      n_fail++; $display("FAIL post_reset: got ma=%b st=%0d want 0 0", major_emergency, state_dbg);
    end
  endtask

  initial begin
    test_reset();
    test_minor_hold();
    test_simultaneous();
    test_timeout();
    test_held_reset();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
